// File: rtl/rgmii_tx_ddr_mux.sv
// rgmii_tx_ddr_mux: turns the MAC's GMII transmit stream into the rising/falling
// half values for the RGMII TXD/TX_CTL/TXC output DDR flops. At 1000M a whole byte
// goes out per clk. At 10/100M each nibble is repeated on both edges for one slow
// TXC period, and the MAC is paced with a one-cycle clock-enable strobe.
module rgmii_tx_ddr_mux #(
  parameter int DIV_100 = 5,
  parameter int DIV_10  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic       mac_gmii_tx_clk_en,
  output logic [3:0] rgmii_txd_1,
  output logic [3:0] rgmii_txd_2,
  output logic       rgmii_tx_ctl_1,
  output logic       rgmii_tx_ctl_2,
  output logic       rgmii_txc_1,
  output logic       rgmii_txc_2
);

  localparam int MAXDIV = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
  localparam int CW     = $clog2(MAXDIV + 1);

  // Per-speed constants: last count of a period, update point, and the two TXC
  // high-time thresholds (rising half high for ceil(P/2), falling half for floor(P/2)).
  localparam logic [CW-1:0] LAST_100 = CW'(DIV_100 - 1);
  localparam logic [CW-1:0] LAST_10  = CW'(DIV_10 - 1);
  localparam logic [CW-1:0] UPD_100  = CW'((DIV_100 + 1) / 2 - 1);
  localparam logic [CW-1:0] UPD_10   = CW'((DIV_10 + 1) / 2 - 1);
  localparam logic [CW-1:0] HI1_100  = CW'((DIV_100 + 1) / 2);
  localparam logic [CW-1:0] HI1_10   = CW'((DIV_10 + 1) / 2);
  localparam logic [CW-1:0] HI2_100  = CW'(DIV_100 / 2);
  localparam logic [CW-1:0] HI2_10   = CW'(DIV_10 / 2);

  logic [1:0]    speed_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          nib_q, nib_d;
  logic [3:0]    txd_1_q, txd_1_d;
  logic [3:0]    txd_2_q, txd_2_d;
  logic          ctl_1_q, ctl_1_d;
  logic          ctl_2_q, ctl_2_d;
  logic [3:0]    hi_q, hi_d;

  logic          gig;
  logic          changed;
  logic          strobe;
  logic [CW-1:0] last_cnt;
  logic [CW-1:0] upd_cnt;
  logic [CW-1:0] hi1_cnt;
  logic [CW-1:0] hi2_cnt;

  // Next-state logic: period counter, nibble phase and the data registers.
  always_comb begin
    gig      = speed_q[1];
    changed  = (speed != speed_q);
    last_cnt = speed_q[0] ? LAST_100 : LAST_10;
    upd_cnt  = speed_q[0] ? UPD_100  : UPD_10;
    hi1_cnt  = speed_q[0] ? HI1_100  : HI1_10;
    hi2_cnt  = speed_q[0] ? HI2_100  : HI2_10;
    strobe   = 1'b0;
    cnt_d    = cnt_q;
    nib_d    = nib_q;
    txd_1_d  = txd_1_q;
    txd_2_d  = txd_2_q;
    ctl_1_d  = ctl_1_q;
    ctl_2_d  = ctl_2_q;
    hi_d     = hi_q;
    if (changed) begin
      cnt_d = '0;
      nib_d = 1'b0;
    end else if (gig) begin
      strobe  = 1'b1;
      cnt_d   = '0;
      nib_d   = 1'b0;
      txd_1_d = gmii_txd[3:0];
      txd_2_d = gmii_txd[7:4];
      ctl_1_d = gmii_tx_en;
      ctl_2_d = gmii_tx_en ^ gmii_tx_er;
    end else begin
      cnt_d = (cnt_q == last_cnt) ? '0 : cnt_q + CW'(1);
      if (cnt_q == upd_cnt) begin
        if (!nib_q) begin
          strobe  = 1'b1;
          txd_1_d = gmii_txd[3:0];
          txd_2_d = gmii_txd[3:0];
          hi_d    = gmii_txd[7:4];
          ctl_1_d = gmii_tx_en;
          ctl_2_d = gmii_tx_en ^ gmii_tx_er;
          nib_d   = 1'b1;
        end else begin
          txd_1_d = hi_q;
          txd_2_d = hi_q;
          nib_d   = 1'b0;
        end
      end
    end
  end

  // State registers; reset clears everything and captures the current speed.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q <= speed;
      cnt_q   <= '0;
      nib_q   <= 1'b0;
      txd_1_q <= '0;
      txd_2_q <= '0;
      ctl_1_q <= 1'b0;
      ctl_2_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      speed_q <= speed;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      txd_1_q <= txd_1_d;
      txd_2_q <= txd_2_d;
      ctl_1_q <= ctl_1_d;
      ctl_2_q <= ctl_2_d;
      hi_q    <= hi_d;
    end
  end

  assign mac_gmii_tx_clk_en = !rst && strobe;
  assign rgmii_txc_1        = !rst && (gig || (cnt_q < hi1_cnt));
  assign rgmii_txc_2        = !rst && !gig && (cnt_q < hi2_cnt);
  assign rgmii_txd_1        = txd_1_q;
  assign rgmii_txd_2        = txd_2_q;
  assign rgmii_tx_ctl_1     = ctl_1_q;
  assign rgmii_tx_ctl_2     = ctl_2_q;

endmodule

// File: tb/tb_rgmii_tx_ddr_mux.sv
// tb_rgmii_tx_ddr_mux: directed bench for the RGMII transmit DDR mux with a
// cycle-counting reference model and a few hand-computed checkpoints.
module tb_rgmii_tx_ddr_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed;
  logic [7:0] txd;
  logic       en;
  logic       er;
  logic       clk_en;
  logic [3:0] txd_1;
  logic [3:0] txd_2;
  logic       ctl_1;
  logic       ctl_2;
  logic       txc_1;
  logic       txc_2;

  int checks = 0;
  int passes = 0;

  // Reference model state: cycles since the last resync and the expected pins.
  int         m_k     = 0;
  logic [1:0] m_speed = 2'b10;
  logic [3:0] m_txd1  = '0;
  logic [3:0] m_txd2  = '0;
  logic [3:0] m_hi    = '0;
  logic       m_ctl1  = 1'b0;
  logic       m_ctl2  = 1'b0;
  bit         m_valid = 1'b0;

  always #5 clk = ~clk;

  rgmii_tx_ddr_mux #(.DIV_100(5), .DIV_10(50)) dut (
    .clk               (clk),
    .rst               (rst),
    .speed             (speed),
    .gmii_txd          (txd),
    .gmii_tx_en        (en),
    .gmii_tx_er        (er),
    .mac_gmii_tx_clk_en(clk_en),
    .rgmii_txd_1       (txd_1),
    .rgmii_txd_2       (txd_2),
    .rgmii_tx_ctl_1    (ctl_1),
    .rgmii_tx_ctl_2    (ctl_2),
    .rgmii_txc_1       (txc_1),
    .rgmii_txc_2       (txc_2)
  );

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
  endtask

  // Drive one cycle of inputs after the falling edge, then settle before returning.
  task automatic apply_stimulus(input logic r, input logic [1:0] s, input logic [7:0] d,
                                input logic e, input logic x);
    @(negedge clk);
    rst   = r;
    speed = s;
    txd   = d;
    en    = e;
    er    = x;
    #2;
  endtask

  // Every cycle: compare the DUT against the model, then step the model across the edge.
  always begin
    int p;
    int u;
    bit gig;
    bit chg;
    logic e_en, e_t1, e_t2;
    @(negedge clk);
    #2;
    p   = m_speed[0] ? 5 : 50;
    u   = (p + 1) / 2 - 1;
    gig = m_speed[1];
    chg = (speed != m_speed);
    e_en = !rst && !chg && (gig || ((m_k % (2 * p)) == u));
    e_t1 = !rst && (gig || ((m_k % p) < (p + 1) / 2));
    e_t2 = !rst && !gig && ((m_k % p) < p / 2);
    if (m_valid)
      check_output("model_cycle",
                   {5'b0, clk_en, txc_1, txc_2, ctl_1, ctl_2, txd_1, txd_2},
                   {5'b0, e_en, e_t1, e_t2, m_ctl1, m_ctl2, m_txd1, m_txd2});
    if (rst) begin
      m_valid = 1'b1;
      m_k     = 0;
      m_speed = speed;
      m_txd1  = '0;
      m_txd2  = '0;
      m_hi    = '0;
      m_ctl1  = 1'b0;
      m_ctl2  = 1'b0;
    end else if (chg) begin
      m_k     = 0;
      m_speed = speed;
    end else if (gig) begin
      m_txd1 = txd[3:0];
      m_txd2 = txd[7:4];
      m_ctl1 = en;
      m_ctl2 = en ^ er;
    end else begin
      if ((m_k % p) == u) begin
        if (((m_k / p) % 2) == 0) begin
          m_txd1 = txd[3:0];
          m_txd2 = txd[3:0];
          m_hi   = txd[7:4];
          m_ctl1 = en;
          m_ctl2 = en ^ er;
        end else begin
          m_txd1 = m_hi;
          m_txd2 = m_hi;
        end
      end
      m_k++;
    end
  end

  initial begin
    int n;
    logic [7:0] d;
    rst   = 1'b1;
    speed = 2'b10;
    txd   = 8'h00;
    en    = 1'b0;
    er    = 1'b0;

    // Reset with random inputs, then release at 1000M.
    apply_stimulus(1'b1, 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    apply_stimulus(1'b1, 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    apply_stimulus(1'b1, 2'b10, 8'($urandom), 1'($urandom), 1'($urandom));
    check_output("reset_outputs",
                 {5'b0, clk_en, txc_1, txc_2, ctl_1, ctl_2, txd_1, txd_2}, 16'h0000);
    apply_stimulus(1'b0, 2'b10, 8'hA5, 1'b1, 1'b0);
    check_output("gig_txc_strobe", {13'b0, clk_en, txc_1, txc_2}, 16'h0006);
    apply_stimulus(1'b0, 2'b10, 8'hA5, 1'b1, 1'b0);
    check_output("gig_byte_a5", {6'b0, ctl_1, ctl_2, txd_1, txd_2}, 16'h035A);

    // Carrier extend / error encoding at 1000M.
    apply_stimulus(1'b0, 2'b10, 8'h0F, 1'b0, 1'b1);
    apply_stimulus(1'b0, 2'b10, 8'h0F, 1'b0, 1'b1);
    check_output("gig_ext_0f", {6'b0, ctl_1, ctl_2, txd_1, txd_2}, 16'h01F0);

    // 100M: bytes 0x3C then 0x81, strobes at k = 2, 12, 22.
    apply_stimulus(1'b0, 2'b01, 8'h0F, 1'b0, 1'b1);
    check_output("chg_to_100_no_strobe", {15'b0, clk_en}, 16'h0000);
    for (int k = 0; k < 25; k++) begin
      d = (k <= 2) ? 8'h3C : ((k <= 12) ? 8'h81 : 8'h00);
      apply_stimulus(1'b0, 2'b01, d, (k <= 12), 1'b0);
      if (k == 2)  check_output("100_strobe_k2", {15'b0, clk_en}, 16'h0001);
      if (k == 2)  check_output("100_txc_k2", {14'b0, txc_1, txc_2}, 16'h0002);
      if (k == 3)  check_output("100_nib_c", {8'b0, txd_1, txd_2}, 16'h00CC);
      if (k == 3)  check_output("100_txc_k3", {14'b0, txc_1, txc_2}, 16'h0000);
      if (k == 7)  check_output("100_no_strobe_k7", {15'b0, clk_en}, 16'h0000);
      if (k == 8)  check_output("100_nib_3", {8'b0, txd_1, txd_2}, 16'h0033);
      if (k == 12) check_output("100_strobe_k12", {15'b0, clk_en}, 16'h0001);
      if (k == 13) check_output("100_nib_1", {8'b0, txd_1, txd_2}, 16'h0011);
      if (k == 18) check_output("100_nib_8", {8'b0, txd_1, txd_2}, 16'h0088);
      if (k == 22) check_output("100_strobe_k22", {15'b0, clk_en}, 16'h0001);
    end

    // Switch to 10M while the high nibble is pending.
    apply_stimulus(1'b0, 2'b00, 8'h96, 1'b1, 1'b0);
    check_output("chg_to_10_no_strobe", {15'b0, clk_en}, 16'h0000);
    n = 0;
    while (n < 200) begin
      apply_stimulus(1'b0, 2'b00, 8'h96, 1'b1, 1'b0);
      n++;
      if (clk_en) break;
    end
    check_output("first_10m_strobe_delay", 16'(n), 16'd25);
    check_output("10_txc_k24", {14'b0, txc_1, txc_2}, 16'h0003);

    // 10M: low nibble at k = 25, high at k = 75, next strobe at k = 124.
    for (int k = 25; k < 126; k++) begin
      apply_stimulus(1'b0, 2'b00, (k < 100) ? 8'h96 : 8'h47, 1'b1, 1'b0);
      if (k == 25)  check_output("10_nib_6", {6'b0, ctl_1, ctl_2, txd_1, txd_2}, 16'h0366);
      if (k == 25)  check_output("10_txc_k25", {14'b0, txc_1, txc_2}, 16'h0000);
      if (k == 50)  check_output("10_txc_k50", {14'b0, txc_1, txc_2}, 16'h0003);
      if (k == 74)  check_output("10_hold_k74", {7'b0, clk_en, txd_1, txd_2}, 16'h0066);
      if (k == 75)  check_output("10_nib_9", {8'b0, txd_1, txd_2}, 16'h0099);
      if (k == 124) check_output("10_strobe_k124", {15'b0, clk_en}, 16'h0001);
      if (k == 125) check_output("10_nib_7", {8'b0, txd_1, txd_2}, 16'h0077);
    end

    // Reset mid-operation, then back to 1000M.
    apply_stimulus(1'b1, 2'b00, 8'h55, 1'b1, 1'b0);
    check_output("midreset_gated", {14'b0, clk_en, txc_1}, 16'h0000);
    apply_stimulus(1'b0, 2'b00, 8'h55, 1'b1, 1'b0);
    check_output("midreset_state", {6'b0, ctl_1, ctl_2, txd_1, txd_2}, 16'h0000);
    apply_stimulus(1'b0, 2'b10, 8'hC3, 1'b1, 1'b1);
    apply_stimulus(1'b0, 2'b10, 8'hC3, 1'b1, 1'b1);
    check_output("gig_after_reset_strobe", {15'b0, clk_en}, 16'h0001);
    apply_stimulus(1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
    check_output("gig_err_c3", {6'b0, ctl_1, ctl_2, txd_1, txd_2}, 16'h023C);
    apply_stimulus(1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'b10, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
